// File: rtl/fp32_unpacker.sv
// fp32_unpacker: two-stage streaming IEEE-754 binary32 field decoder with full backpressure.
// Classifies each word, normalizes denormals and keeps saturating NaN/denormal statistics.
module fp32_unpacker #(
  parameter int EXP_W        = 8,
  parameter int MANT_W       = 23,
  parameter bit FLUSH_DENORM = 1'b0,
  parameter int STAT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic signed [EXP_W+1:0] out_exp,
  output logic [MANT_W:0]         out_sig,
  output logic                    out_is_zero,
  output logic                    out_is_denorm,
  output logic                    out_is_inf,
  output logic                    out_is_nan,
  output logic                    out_is_snan,
  input  logic                    stat_clr,
  output logic [STAT_W-1:0]       stat_nan_cnt,
  output logic [STAT_W-1:0]       stat_denorm_cnt
);

  localparam int LZ_W = $clog2(MANT_W + 1);
  localparam int XW   = EXP_W + 2;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);

  logic              inSign;
  logic [EXP_W-1:0]  inExp;
  logic [MANT_W-1:0] inMant;
  logic              expZero, expOnes, mantZero;
  logic [LZ_W-1:0]   lzCount;

  assign {inSign, inExp, inMant} = in_data;
  assign expZero  = (inExp == '0);
  assign expOnes  = &inExp;
  assign mantZero = (inMant == '0);

  // Last hit in an ascending scan is the most significant set bit of the mantissa.
  always_comb begin
    lzCount = LZ_W'(MANT_W - 1);
    for (int i = 0; i < MANT_W; i++) begin
      if (inMant[i]) lzCount = LZ_W'(MANT_W - 1 - i);
    end
  end

  // Stage 1 state
  logic              s1V_q, s1V_d;
  logic              s1Sign_q;
  logic [EXP_W-1:0]  s1Exp_q;
  logic [MANT_W-1:0] s1Mant_q;
  logic [LZ_W-1:0]   s1Lz_q;
  logic              s1Zero_q, s1Denorm_q, s1Inf_q, s1Nan_q;
  logic              s1Zero_d, s1Denorm_d, s1Inf_d, s1Nan_d;

  // Stage 2 state
  logic              s2V_q, s2V_d;
  logic              s2Sign_q;
  logic [XW-1:0]     s2Exp_q, s2Exp_d;
  logic [MANT_W:0]   s2Sig_q, s2Sig_d;
  logic              s2Zero_q, s2Denorm_q, s2Inf_q, s2Nan_q, s2Snan_q;
  logic              s2Snan_d;

  logic [STAT_W-1:0] nanCnt_q, nanCnt_d;
  logic [STAT_W-1:0] denCnt_q, denCnt_d;

  logic s2Ready, s1Load, s2Load, outXfer;

  assign s2Ready  = !s2V_q || out_ready;
  assign in_ready = !s1V_q || s2Ready;
  assign s1Load   = in_valid && in_ready;
  assign s2Load   = s1V_q && s2Ready;
  assign outXfer  = s2V_q && out_ready;

  assign s1V_d = in_ready ? in_valid : s1V_q;
  assign s2V_d = s2Ready ? s1V_q : s2V_q;

  assign s1Denorm_d = expZero && !mantZero;
  assign s1Zero_d   = expZero && (mantZero || FLUSH_DENORM);
  assign s1Inf_d    = expOnes && mantZero;
  assign s1Nan_d    = expOnes && !mantZero;

  // A flushed denormal carries s1Zero_q, so the zero branch must win over the denormal one.
  always_comb begin
    s2Exp_d  = '0;
    s2Sig_d  = '0;
    s2Snan_d = s1Nan_q && !s1Mant_q[MANT_W-1];
    if (s1Nan_q) begin
      s2Sig_d = {1'b1, s1Mant_q};
    end else if (s1Zero_q || s1Inf_q) begin
      s2Sig_d = '0;
    end else if (s1Denorm_q) begin
      s2Exp_d = -BIAS - XW'(s1Lz_q);
      s2Sig_d = {s1Mant_q, 1'b0} << s1Lz_q;
    end else begin
      s2Exp_d = XW'(s1Exp_q) - BIAS;
      s2Sig_d = {1'b1, s1Mant_q};
    end
  end

  always_comb begin
    nanCnt_d = nanCnt_q;
    denCnt_d = denCnt_q;
    if (stat_clr) begin
      nanCnt_d = '0;
      denCnt_d = '0;
    end else if (outXfer) begin
      if (s2Nan_q && (nanCnt_q != '1))    nanCnt_d = nanCnt_q + STAT_W'(1);
      if (s2Denorm_q && (denCnt_q != '1)) denCnt_d = denCnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1V_q      <= 1'b0;
      s1Sign_q   <= 1'b0;
      s1Exp_q    <= '0;
      s1Mant_q   <= '0;
      s1Lz_q     <= '0;
      s1Zero_q   <= 1'b0;
      s1Denorm_q <= 1'b0;
      s1Inf_q    <= 1'b0;
      s1Nan_q    <= 1'b0;
      s2V_q      <= 1'b0;
      s2Sign_q   <= 1'b0;
      s2Exp_q    <= '0;
      s2Sig_q    <= '0;
      s2Zero_q   <= 1'b0;
      s2Denorm_q <= 1'b0;
      s2Inf_q    <= 1'b0;
      s2Nan_q    <= 1'b0;
      s2Snan_q   <= 1'b0;
      nanCnt_q   <= '0;
      denCnt_q   <= '0;
    end else begin
      s1V_q    <= s1V_d;
      s2V_q    <= s2V_d;
      nanCnt_q <= nanCnt_d;
      denCnt_q <= denCnt_d;
      if (s1Load) begin
        s1Sign_q   <= inSign;
        s1Exp_q    <= inExp;
        s1Mant_q   <= inMant;
        s1Lz_q     <= lzCount;
        s1Zero_q   <= s1Zero_d;
        s1Denorm_q <= s1Denorm_d;
        s1Inf_q    <= s1Inf_d;
        s1Nan_q    <= s1Nan_d;
      end
      if (s2Load) begin
        s2Sign_q   <= s1Sign_q;
        s2Exp_q    <= s2Exp_d;
        s2Sig_q    <= s2Sig_d;
        s2Zero_q   <= s1Zero_q;
        s2Denorm_q <= s1Denorm_q;
        s2Inf_q    <= s1Inf_q;
        s2Nan_q    <= s1Nan_q;
        s2Snan_q   <= s2Snan_d;
      end
    end
  end

  assign out_valid       = s2V_q;
  assign out_sign        = s2Sign_q;
  assign out_exp         = s2Exp_q;
  assign out_sig         = s2Sig_q;
  assign out_is_zero     = s2Zero_q;
  assign out_is_denorm   = s2Denorm_q;
  assign out_is_inf      = s2Inf_q;
  assign out_is_nan      = s2Nan_q;
  assign out_is_snan     = s2Snan_q;
  assign stat_nan_cnt    = nanCnt_q;
  assign stat_denorm_cnt = denCnt_q;

endmodule

// File: tb/tb_fp32_unpacker.sv
// Bench for fp32_unpacker: one default instance and one FLUSH_DENORM=1/STAT_W=2 instance share stimulus.
// Expected results come from a hand-computed vector table fed through a scoreboard queue.
module tb_fp32_unpacker;

  typedef struct {
    logic [31:0] data;
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] sig;
    logic        zero, denorm, inf, nan, snan;
  } vec_t;

  typedef struct {
    vec_t v;
    int   stamp;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic        statClr = 1'b0;
  logic [31:0] inData = '0;

  logic        inReadyA, outValidA, outSignA, zeroA, denA, infA, nanA, snanA;
  logic [9:0]  outExpA;
  logic [23:0] outSigA;
  logic [15:0] nanCntA, denCntA;

  logic        inReadyB, outValidB, outSignB, zeroB, denB, infB, nanB, snanB;
  logic [9:0]  outExpB;
  logic [23:0] outSigB;
  logic [1:0]  nanCntB, denCntB;

  fp32_unpacker dutA (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReadyA), .in_data(inData),
    .out_valid(outValidA), .out_ready(outReady), .out_sign(outSignA), .out_exp(outExpA),
    .out_sig(outSigA), .out_is_zero(zeroA), .out_is_denorm(denA), .out_is_inf(infA),
    .out_is_nan(nanA), .out_is_snan(snanA), .stat_clr(statClr),
    .stat_nan_cnt(nanCntA), .stat_denorm_cnt(denCntA)
  );

  fp32_unpacker #(.FLUSH_DENORM(1'b1), .STAT_W(2)) dutB (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReadyB), .in_data(inData),
    .out_valid(outValidB), .out_ready(outReady), .out_sign(outSignB), .out_exp(outExpB),
    .out_sig(outSigB), .out_is_zero(zeroB), .out_is_denorm(denB), .out_is_inf(infB),
    .out_is_nan(nanB), .out_is_snan(snanB), .stat_clr(statClr),
    .stat_nan_cnt(nanCntB), .stat_denorm_cnt(denCntB)
  );

  int   checks = 0;
  int   errors = 0;
  int   edgeCnt = 0;
  sb_t  sb[$];
  int   mNanA = 0, mDenA = 0, mNanB = 0, mDenB = 0;
  vec_t tab[15];

  function automatic vec_t mk(input logic [31:0] d, input logic s, input logic [9:0] e,
                              input logic [23:0] g, input logic [4:0] f);
    vec_t r;
    r.data = d; r.sign = s; r.exp = e; r.sig = g;
    {r.zero, r.denorm, r.inf, r.nan, r.snan} = f;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // The flushing instance sees a denormal as a signed zero that still reports its denormal origin.
  task automatic checkOutput(input sb_t e);
    string tag;
    logic [9:0]  fExp;
    logic [23:0] fSig;
    tag  = $sformatf("%08h", e.v.data);
    fExp = e.v.denorm ? 10'h000 : e.v.exp;
    fSig = e.v.denorm ? 24'h000000 : e.v.sig;
    check({"A.sign ", tag}, outSignA, e.v.sign);
    check({"A.exp ", tag}, outExpA, e.v.exp);
    check({"A.sig ", tag}, outSigA, e.v.sig);
    check({"A.flags ", tag}, {zeroA, denA, infA, nanA, snanA},
          {e.v.zero, e.v.denorm, e.v.inf, e.v.nan, e.v.snan});
    check({"B.sign ", tag}, outSignB, e.v.sign);
    check({"B.exp ", tag}, outExpB, fExp);
    check({"B.sig ", tag}, outSigB, fSig);
    check({"B.flags ", tag}, {zeroB, denB, infB, nanB, snanB},
          {e.v.zero | e.v.denorm, e.v.denorm, e.v.inf, e.v.nan, e.v.snan});
  endtask

  // One clock: drive inputs, check handshake/outputs against the scoreboard, then check counters.
  task automatic applyStimulus(input vec_t v, input logic vld, input logic rdy,
                               input logic clr, input logic rst, output logic acc);
    logic expReady, expValid, xfer;
    sb_t  ent;
    rstN     = !rst;
    inValid  = vld;
    inData   = v.data;
    outReady = rdy;
    statClr  = clr;
    acc      = 1'b0;
    #1;
    if (rstN) begin
      expReady = (sb.size() < 2) || outReady;
      expValid = (sb.size() > 0) && (edgeCnt >= sb[0].stamp + 2);
      check("A.in_ready", inReadyA, expReady);
      check("B.in_ready", inReadyB, expReady);
      check("A.out_valid", outValidA, expValid);
      check("B.out_valid", outValidB, expValid);
      if (expValid) checkOutput(sb[0]);
      xfer = expValid && outReady;
      acc  = inValid && expReady;
      if (statClr) begin
        mNanA = 0; mDenA = 0; mNanB = 0; mDenB = 0;
      end else if (xfer) begin
        if (sb[0].v.nan) begin
          if (mNanA < 65535) mNanA++;
          if (mNanB < 3) mNanB++;
        end
        if (sb[0].v.denorm) begin
          if (mDenA < 65535) mDenA++;
          if (mDenB < 3) mDenB++;
        end
      end
      if (xfer) void'(sb.pop_front());
      if (acc) begin
        ent.v = v;
        ent.stamp = edgeCnt;
        sb.push_back(ent);
      end
    end
    @(posedge clk);
    edgeCnt++;
    if (!rstN) begin
      sb.delete();
      mNanA = 0; mDenA = 0; mNanB = 0; mDenB = 0;
    end
    #1;
    check("A.stat_nan_cnt", nanCntA, mNanA);
    check("A.stat_denorm_cnt", denCntA, mDenA);
    check("B.stat_nan_cnt", nanCntB, mNanB);
    check("B.stat_denorm_cnt", denCntB, mDenB);
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   idx;
    logic sawReadyLow;
    vec_t stream[4];

    tab[0]  = mk(32'h3F800000, 1'b0, 10'h000, 24'h800000, 5'b00000);
    tab[1]  = mk(32'h00000001, 1'b0, 10'h36B, 24'h800000, 5'b01000);
    tab[2]  = mk(32'h80400000, 1'b1, 10'h381, 24'h800000, 5'b01000);
    tab[3]  = mk(32'hFF800000, 1'b1, 10'h000, 24'h000000, 5'b00100);
    tab[4]  = mk(32'h7FC00000, 1'b0, 10'h000, 24'hC00000, 5'b00010);
    tab[5]  = mk(32'h7F800001, 1'b0, 10'h000, 24'h800001, 5'b00011);
    tab[6]  = mk(32'h80000000, 1'b1, 10'h000, 24'h000000, 5'b10000);
    tab[7]  = mk(32'h00000000, 1'b0, 10'h000, 24'h000000, 5'b10000);
    tab[8]  = mk(32'hC0490FDB, 1'b1, 10'h001, 24'hC90FDB, 5'b00000);
    tab[9]  = mk(32'h007FFFFF, 1'b0, 10'h381, 24'hFFFFFE, 5'b01000);
    tab[10] = mk(32'h7F7FFFFF, 1'b0, 10'h07F, 24'hFFFFFF, 5'b00000);
    tab[11] = mk(32'h00800000, 1'b0, 10'h382, 24'h800000, 5'b00000);
    tab[12] = mk(32'h00000300, 1'b0, 10'h374, 24'hC00000, 5'b01000);
    tab[13] = mk(32'h7FFFFFFF, 1'b0, 10'h000, 24'hFFFFFF, 5'b00010);
    tab[14] = mk(32'hFFA00000, 1'b1, 10'h000, 24'hA00000, 5'b00011);

    $display("[TB] reset");
    applyStimulus(tab[0], 1'b0, 1'b1, 1'b0, 1'b1, acc);
    applyStimulus(tab[0], 1'b0, 1'b1, 1'b0, 1'b1, acc);
    check("reset out_valid", outValidA, 1'b0);
    check("reset out_sig", outSigA, 24'h000000);

    $display("[TB] single word latency");
    applyStimulus(tab[0], 1'b1, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(tab[0], 1'b0, 1'b1, 1'b0, 1'b0, acc);

    $display("[TB] vector table back-to-back");
    for (int i = 0; i < 15; i++) applyStimulus(tab[i], 1'b1, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) applyStimulus(tab[0], 1'b0, 1'b1, 1'b0, 1'b0, acc);
    check("table drained", sb.size(), 0);
    check("A nan count after table", nanCntA, 16'd4);
    check("A denorm count after table", denCntA, 16'd4);
    check("B denorm count saturated", denCntB, 2'd3);

    $display("[TB] backpressure");
    stream[0] = tab[0]; stream[1] = tab[8]; stream[2] = tab[10]; stream[3] = tab[11];
    idx = 0;
    sawReadyLow = 1'b0;
    for (int j = 0; j < 14; j++) begin
      applyStimulus(stream[idx % 4], idx < 4, j >= 5, 1'b0, 1'b0, acc);
      if (acc) idx++;
      if (j == 3 && inReadyA === 1'b0) sawReadyLow = 1'b1;
    end
    check("backpressure in_ready fell", sawReadyLow, 1'b1);
    check("backpressure all sent", idx, 4);
    check("backpressure drained", sb.size(), 0);

    $display("[TB] counter saturation and clear priority");
    applyStimulus(tab[0], 1'b0, 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 5; i++) applyStimulus(tab[4], 1'b1, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(tab[0], 1'b0, 1'b1, 1'b0, 1'b0, acc);
    check("B nan count holds at 3", nanCntB, 2'd3);
    check("A nan count is 5", nanCntA, 16'd5);
    applyStimulus(tab[5], 1'b1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(tab[0], 1'b0, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(tab[0], 1'b0, 1'b1, 1'b1, 1'b0, acc);
    check("clear beats increment A", nanCntA, 16'd0);
    check("clear beats increment B", nanCntB, 2'd0);

    $display("[TB] reset mid-stream");
    applyStimulus(tab[1], 1'b1, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(tab[4], 1'b1, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(tab[0], 1'b0, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(tab[8], 1'b1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(tab[10], 1'b1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(tab[0], 1'b0, 1'b1, 1'b0, 1'b1, acc);
    check("mid reset out_valid", outValidA, 1'b0);
    check("mid reset in_ready", inReadyA, 1'b1);
    check("mid reset nan count", nanCntA, 16'd0);
    check("mid reset denorm count", denCntA, 16'd0);
    for (int i = 0; i < 5; i++) applyStimulus(tab[0], 1'b0, 1'b1, 1'b0, 1'b0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
